// File: rtl/seq_mul_ctrl.sv
// Shift-and-add 32x32 unsigned sequential multiplier controller driving an external adder.
// Optional macro SEQ_MUL_ZERO_SKIP_EN: a zero operand skips RUN and completes at once.
module seq_mul_ctrl #(
    parameter logic [2:0] ADD_OP = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [2:0]  add_op,
    input  logic [31:0] add_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_count;
    logic [31:0] r_mcand;
    logic [31:0] r_prod_hi;
    logic [31:0] r_prod_lo;

    logic        w_skip;
    logic        w_sel;
    logic [31:0] w_sum;
    logic        w_carry;

`ifdef SEQ_MUL_ZERO_SKIP_EN
    assign w_skip = (A == 32'd0) || (B == 32'd0);
`else
    assign w_skip = 1'b0;
`endif

    assign add_a  = r_prod_hi;
    assign add_b  = r_mcand;
    assign add_op = ADD_OP;

    // Carry out of the 32-bit add, recovered from the operand and result sign bits.
    assign w_sel   = r_prod_lo[0];
    assign w_sum   = w_sel ? add_result : r_prod_hi;
    assign w_carry = w_sel & ((add_a[31] & add_b[31]) |
                              ((add_a[31] | add_b[31]) & ~add_result[31]));

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign product_hi = r_prod_hi;
    assign product_lo = r_prod_lo;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = w_skip ? S_DONE : S_RUN;
            S_RUN:  if (r_count == 5'd31) w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 5'd0;
            r_mcand   <= 32'd0;
            r_prod_hi <= 32'd0;
            r_prod_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand   <= A;
                        r_count   <= 5'd0;
                        r_prod_hi <= 32'd0;
                        r_prod_lo <= w_skip ? 32'd0 : B;
                    end
                end
                S_RUN: begin
                    {r_prod_hi, r_prod_lo} <= {w_carry, w_sum, r_prod_lo[31:1]};
                    r_count                <= r_count + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_mul_ctrl.md
SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 The block SHALL have parameter ADD_OP, default 3'b101, the adder opcode that selects A+B with carry-in 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have ports A and B, input, 32 each, the unsigned multiplicand (A) and multiplier (B); sampled with start.
REQ-006 The block SHALL have port busy, output, 1, high while the RUN state is active.
REQ-007 The block SHALL have port done, output, 1, a one-cycle pulse indicating the product is valid.
REQ-008 The block SHALL have ports product_hi and product_lo, output, 32 each, the 64-bit product registers.
REQ-009 The block SHALL have ports add_a, add_b (output, 32 each), add_op (output, 3) and add_result (input, 32): the drive to, and return from, the external combinational 32-bit add/sub unit.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE, plus a 5-bit iteration counter.
REQ-011 In IDLE with start=1, it SHALL latch A into the multiplicand register, clear product_hi, load B into product_lo, clear the counter and enter RUN.
REQ-012 add_a SHALL equal product_hi, add_b SHALL equal the multiplicand register, and add_op SHALL equal ADD_OP constantly.
REQ-013 Each RUN cycle, with sel = product_lo[0]:
- sum = sel ? add_result : product_hi
- carry = sel & ((add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~add_result[31]))
- {product_hi, product_lo} <= {carry, sum, product_lo[31:1]}
REQ-014 RUN SHALL last exactly 32 cycles (counter 0..31) and then enter DONE.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-016 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+33.
REQ-017 The product SHALL equal A*B (unsigned, 64-bit, no overflow possible) and SHALL hold until the next accepted start.
REQ-018 start SHALL be ignored in RUN and DONE: no restart and no change to operands.
REQ-019 busy and done SHALL never be high together.

Reset
REQ-020 rst=1 SHALL immediately force state IDLE, counter 0, multiplicand 0, product_hi 0, product_lo 0, busy 0 and done 0.
REQ-021 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh multiply.

Configuration
REQ-022 With macro SEQ_MUL_ZERO_SKIP_EN defined, a start in IDLE with A==0 or B==0 SHALL clear both product registers and go directly to DONE (done at edge k+1, busy never asserted).
REQ-023 Without SEQ_MUL_ZERO_SKIP_EN, zero operands SHALL take the full 32-cycle RUN path of REQ-014.

Verification
REQ-024 Basic multiply: A=3, B=5, start at edge k -> done high after edge k+33; product_hi=0, product_lo=15; busy high for exactly 32 cycles.
REQ-025 Carry path: A=B=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001.
REQ-026 Busy protection: start with A=7, B=6, then start with A=1, B=1 asserted during RUN -> single done pulse, product=42.
REQ-027 Reset abort: rst pulsed 10 cycles into RUN -> outputs all 0 and no done; a following start with A=2, B=9 -> product 18 after 33 cycles.
REQ-028 Zero operand: A=0, B=123 -> product 0; done after edge k+1 with SEQ_MUL_ZERO_SKIP_EN defined, after edge k+33 without it.
REQ-029 Random regression: 1000 random unsigned A, B pairs -> every product matches the 64-bit reference model, and add_op reads 3'b101 in every cycle.
